pooling_stream: RTL

//  Streaming, channel-parallel pooling stage; successor of the fixed 2x2 average pooler.

---
 rtl/pooling_pkg.sv | 19 +
 rtl/pooling_lane.sv | 60 ++++++
 rtl/pooling_stream.sv | 100 ++++++++++
 3 files changed

// File: rtl/pooling_pkg.sv
// Shared types and width helpers for the streaming pooling stage.
package pooling_pkg;

    typedef enum logic {
        POOL_AVG = 1'b0,
        POOL_MAX = 1'b1
    } pool_mode_e;

    // Window counter width; also the right-shift amount for averaging.
    function automatic int cnt_w(input int win);
        return $clog2(win);
    endfunction

    // Accumulator width: a full window of DATA_W values sums without overflow.
    function automatic int acc_w(input int data_w, input int win);
        return data_w + cnt_w(win);
    endfunction

endpackage

// File: rtl/pooling_lane.sv
// One channel of the pooling stage: window accumulator, running signed max,
// and the finalise mux that turns the current beat plus history into a result.
module pooling_lane
    import pooling_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int WIN      = 4,
    parameter bit ROUND_EN = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     first,
    input  logic                     accept,
    input  logic                     clear,
    input  pool_mode_e               mode_q,
    input  logic signed [DATA_W-1:0] in_data,
    output logic signed [DATA_W-1:0] result
);

    localparam int L     = cnt_w(WIN);
    localparam int ACC_W = acc_w(DATA_W, WIN);
    localparam logic signed [ACC_W-1:0] RND = ROUND_EN ? ACC_W'(1 << (L - 1)) : '0;

    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  in_ext, sum, sum_rnd;
    logic signed [DATA_W-1:0] max_q, max_d, max_v;

    // Combine the incoming beat with the held state and form the finalised value.
    // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
    always_comb begin
        in_ext  = ACC_W'(in_data);
        sum     = acc_q + in_ext;
        max_v   = (in_data > max_q) ? in_data : max_q;
        sum_rnd = sum + RND;
        result  = (mode_q == POOL_MAX) ? max_v : DATA_W'(sum_rnd >>> L);

        acc_d = acc_q;
        max_d = max_q;
        if (clear) begin
            acc_d = '0;
            max_d = '0;
        end else if (accept) begin
            acc_d = first ? in_ext : sum;
            max_d = first ? in_data : max_v;
        end
    end

    // Accumulator and max registers; cleared by reset and by a window discard.
    // NOTE: state updates use non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            max_q <= '0;
        end else begin
            acc_q <= acc_d;
            max_q <= max_d;
        end
    end

endmodule

// File: rtl/pooling_stream.sv
// Streaming channel-parallel pooling: WIN beats in, one pooled value per channel out,
// with valid/ready on both sides and a single output register (no skid buffer).
module pooling_stream
    import pooling_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int CH       = 64,
    parameter int WIN      = 4,
    parameter bit ROUND_EN = 1'b0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             mode,
    input  logic                             win_clear,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic signed [CH-1:0][DATA_W-1:0] in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic signed [CH-1:0][DATA_W-1:0] out_data,
    output logic                             busy
);

    localparam int CNT_W = cnt_w(WIN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIN - 1);

    if (WIN < 2 || (WIN & (WIN - 1)) != 0) begin : g_bad_win
        $error("pooling_stream: WIN must be a power of two and >= 2");
    end

    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    pool_mode_e                       mode_q, mode_d;
    logic                             out_valid_q, out_valid_d;
    logic signed [CH-1:0][DATA_W-1:0] out_data_q, out_data_d;
    logic signed [CH-1:0][DATA_W-1:0] lane_res;
    logic                             accept, first, last;

    assign in_ready  = ~out_valid_q | out_ready;
    assign accept    = in_valid & in_ready & ~win_clear;
    assign first     = (cnt_q == '0);
    assign last      = (cnt_q == LAST_CNT);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (cnt_q != '0);

    for (genvar g = 0; g < CH; g++) begin : g_lane
        pooling_lane #(
            .DATA_W  (DATA_W),
            .WIN     (WIN),
            .ROUND_EN(ROUND_EN)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .first  (first),
            .accept (accept),
            .clear  (win_clear),
            .mode_q (mode_q),
            .in_data(in_data[g]),
            .result (lane_res[g])
        );
    end

    // Window counter, mode latch and output register next-state.
    always_comb begin
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (win_clear) begin
            cnt_d = '0;
        end else if (accept) begin
            if (first) mode_d = pool_mode_e'(mode);
            cnt_d = last ? '0 : cnt_q + 1'b1;
        end

        if (accept && last) begin
            out_valid_d = 1'b1;
            out_data_d  = lane_res;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            mode_q      <= POOL_AVG;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule
